// File: rtl/mem_pkg.sv
// Shared types and constants for the IF/D memory arbiter and related
// memory-side logic.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RSP,
        RMW_WR,
        ACK
    } state_t;

    typedef enum logic {
        SRC_IF,
        SRC_D
    } src_t;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam int         MEM_AW  = 10;

endpackage

// File: rtl/mem_arbiter_be_merge.sv
// Byte-lane merge: each lane takes the new byte when its enable is set,
// otherwise keeps the old byte.
module be_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] old_i,
    input  logic [DW-1:0] new_i,
    input  logic [3:0]    be_i,
    output logic [DW-1:0] merged_o
);

    localparam int LW = DW / 4;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_o[gi*LW +: LW] = be_i[gi] ? new_i[gi*LW +: LW]
                                                    : old_i[gi*LW +: LW];
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory controller shared by instruction fetch and load/store;
// arbitrates, sequences accesses and turns partial stores into read-modify-write.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW    = MEM_AW,
    parameter int DW    = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW+1:0] if_addr,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rsp_data,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW+1:0] d_addr,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t        state_q, state_d;
    src_t          src_q, src_d;
    src_t          rr_last_q, rr_last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          grant_if, grant_d;
    logic [DW-1:0] merged;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    be_merge #(.DW(DW)) u_be_merge (
        .old_i    (mem_rdata),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    // Grants exist only in IDLE and never while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (RR_EN) begin
                if (if_req_valid && d_req_valid) begin
                    grant_if = (rr_last_q == SRC_D);
                    grant_d  = (rr_last_q == SRC_IF);
                end else begin
                    grant_if = if_req_valid;
                    grant_d  = d_req_valid;
                end
            end else begin
                grant_d  = d_req_valid;
                grant_if = if_req_valid & ~d_req_valid;
            end
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;
    assign mem_be       = BE_FULL;
    assign busy         = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        rr_last_d    = rr_last_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        mem_addr     = addr_q;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    src_d     = SRC_IF;
                    rr_last_d = SRC_IF;
                    addr_d    = if_addr[AW+1:2];
                    we_d      = 1'b0;
                    be_d      = '0;
                    wdata_d   = '0;
                    mem_addr  = if_addr[AW+1:2];
                    state_d   = RSP;
                end else if (grant_d) begin
                    src_d     = SRC_D;
                    rr_last_d = SRC_D;
                    addr_d    = d_addr[AW+1:2];
                    we_d      = d_we;
                    be_d      = d_be;
                    wdata_d   = d_wdata;
                    mem_addr  = d_addr[AW+1:2];
                    if (d_we && d_be == BE_FULL) begin
                        mem_we    = 1'b1;
                        mem_wdata = d_wdata;
                        state_d   = RSP;
                    end else if (d_we && d_be != 4'h0) begin
                        // Read phase of the RMW; the old word arrives next cycle.
                        state_d = RMW_WR;
                    end else begin
                        state_d = RSP;
                    end
                end
            end
            RMW_WR: begin
                mem_we    = we_q;
                mem_wdata = merged;
                state_d   = ACK;
            end
            RSP, ACK: begin
                if (src_q == SRC_IF) begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = mem_rdata;
                end else begin
                    d_rsp_valid = 1'b1;
                    d_rsp_data  = mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= SRC_IF;
            rr_last_q <= SRC_D;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level
// reference model of the shared memory and the arbitration rules.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_valid, d_req_valid, d_we;
    logic [11:0] if_addr, d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid;
    logic [31:0] if_rsp_data, d_rsp_data, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we, busy;
    logic [3:0]  mem_be;

    logic        fp_if_req_ready, fp_d_req_ready, fp_if_rsp_valid, fp_d_rsp_valid;
    logic [31:0] fp_if_rsp_data, fp_d_rsp_data, fp_mem_wdata, fp_mem_rdata;
    logic [9:0]  fp_mem_addr;
    logic        fp_mem_we, fp_busy;
    logic [3:0]  fp_mem_be;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(.AW(10), .DW(32), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(10), .DW(32), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(fp_if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(fp_if_rsp_valid), .if_rsp_data(fp_if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(fp_d_req_ready), .d_addr(d_addr),
        .d_we(1'b0), .d_be(d_be), .d_wdata(d_wdata),
        .d_rsp_valid(fp_d_rsp_valid), .d_rsp_data(fp_d_rsp_data),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we),
        .mem_be(fp_mem_be), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Physical memory: registered read, read-before-write, plus a preload port.
    logic [31:0] mem [0:1023];
    logic        pl_we;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) fp_mem_rdata <= {22'h0, fp_mem_addr} ^ 32'hA5A50000;

    function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference model: word array, next-free cycle, one outstanding response.
    int          cyc = 0;
    logic [31:0] refm [0:1023];
    int          free_at, exp_due, rmw_cyc, idx_e;
    bit          last_d, exp_v, exp_d_src, rmw_pend;
    bit          idle_e, gi_e, gd_e, full_e, part_e, eri, erd;
    logic [31:0] exp_data, rmw_val;
    logic [9:0]  rmw_idx;
    int          if_acc_cnt = 0, d_acc_cnt = 0;
    int          grant_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pl_we) refm[pl_idx] = pl_data;
        if (!rst_n) begin
            exp_v = 0; rmw_pend = 0; free_at = 0; last_d = 1;
        end else begin
            idle_e = (cyc >= free_at);
            gi_e = 0; gd_e = 0;
            if (idle_e) begin
                if (if_req_valid && d_req_valid) begin
                    gi_e = last_d; gd_e = !last_d;
                end else begin
                    gi_e = if_req_valid; gd_e = d_req_valid;
                end
            end
            chk("if_ready", {31'b0, if_req_ready}, {31'b0, gi_e});
            chk("d_ready", {31'b0, d_req_ready}, {31'b0, gd_e});
            chk("busy", {31'b0, busy}, {31'b0, !idle_e});
            chk("mem_be", {28'b0, mem_be}, 32'hF);
            eri = exp_v && exp_due == cyc && !exp_d_src;
            erd = exp_v && exp_due == cyc && exp_d_src;
            chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, eri});
            chk("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, erd});
            if (eri) chk("if_rsp_data", if_rsp_data, exp_data);
            if (erd) chk("d_rsp_data", d_rsp_data, exp_data);
            if (eri || erd) exp_v = 0;
            chk("rsp_overlap", {31'b0, (if_rsp_valid | d_rsp_valid) & (if_req_ready | d_req_ready)}, 0);
            if (rmw_pend && cyc == rmw_cyc) begin
                chk("rmw_we", {31'b0, mem_we}, 1);
                chk("rmw_addr", {22'b0, mem_addr}, {22'b0, rmw_idx});
                chk("rmw_wdata", mem_wdata, rmw_val);
            end
            if (rmw_pend && cyc == rmw_cyc + 1) begin
                refm[rmw_idx] = rmw_val;
                rmw_pend = 0;
            end
            if (gi_e) begin
                idx_e = int'(if_addr[11:2]);
                chk("acc_if_addr", {22'b0, mem_addr}, idx_e);
                chk("acc_if_we", {31'b0, mem_we}, 0);
                exp_v = 1; exp_d_src = 0; exp_data = refm[idx_e];
                exp_due = cyc + 1; free_at = cyc + 2; last_d = 0;
                if_acc_cnt++; grant_log.push_back(0);
            end else if (gd_e) begin
                idx_e  = int'(d_addr[11:2]);
                full_e = d_we && d_be == 4'hF;
                part_e = d_we && d_be != 4'h0 && d_be != 4'hF;
                chk("acc_d_addr", {22'b0, mem_addr}, idx_e);
                chk("acc_d_we", {31'b0, mem_we}, {31'b0, full_e});
                exp_v = 1; exp_d_src = 1; exp_data = refm[idx_e]; last_d = 1;
                if (full_e) begin
                    chk("acc_d_wdata", mem_wdata, d_wdata);
                    refm[idx_e] = d_wdata;
                end
                if (part_e) begin
                    rmw_pend = 1; rmw_cyc = cyc + 1; rmw_idx = d_addr[11:2];
                    rmw_val = merge_ref(refm[idx_e], d_wdata, d_be);
                    exp_due = cyc + 2;
                end else begin
                    exp_due = cyc + 1;
                end
                free_at = exp_due + 1;
                d_acc_cnt++; grant_log.push_back(1);
            end
        end
    end

    task automatic preload(input logic [9:0] i, input logic [31:0] v);
        pl_idx = i; pl_data = v; pl_we = 1'b1;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic if_op(input logic [11:0] a, output logic [31:0] rd);
        bit ok;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = a;
        ok = 0;
        for (int k = 0; k < 16 && !ok; k++) begin @(negedge clk); ok = if_req_ready; end
        chk("if_accept_bound", {31'b0, ok}, 1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        ok = 0; rd = '0;
        for (int k = 0; k < 4 && !ok; k++) begin
            @(negedge clk);
            if (if_rsp_valid) begin ok = 1; rd = if_rsp_data; end
        end
        chk("if_rsp_bound", {31'b0, ok}, 1);
    endtask

    task automatic d_op(input logic [11:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
        bit ok;
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_addr = a; d_we = we; d_be = be; d_wdata = wd;
        ok = 0;
        for (int k = 0; k < 16 && !ok; k++) begin @(negedge clk); ok = d_req_ready; end
        chk("d_accept_bound", {31'b0, ok}, 1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        ok = 0; rd = '0; lat = 0;
        for (int k = 0; k < 4 && !ok; k++) begin
            @(negedge clk);
            lat++;
            if (d_rsp_valid) begin ok = 1; rd = d_rsp_data; end
        end
        chk("d_rsp_bound", {31'b0, ok}, 1);
    endtask

    function automatic logic [11:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        if (r[10:8] == 3'd0) return r[31:20];
        return {4'h0, r[7:0]};
    endfunction

    initial begin
        logic [31:0] rd;
        int          lat, if_seen, d_seen;
        bit          seen_fp_if;
        logic [3:0]  be_r;

        rst_n = 1'b0; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        if_req_valid = 1'b0; d_req_valid = 1'b0; if_addr = '0; d_addr = '0;
        d_we = 1'b0; d_be = '0; d_wdata = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) preload(10'(i), $urandom);
        preload(10'd1, 32'h8C010000);
        preload(10'd4, 32'h12345678);

        // Reset state with both requesters asking.
        if_req_valid = 1'b1; d_req_valid = 1'b1; #1;
        chk("rst_if_ready", {31'b0, if_req_ready}, 0);
        chk("rst_d_ready", {31'b0, d_req_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'hF);
        chk("rst_rsp", {30'b0, if_rsp_valid, d_rsp_valid}, 0);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;

        if_op(12'h004, rd);
        chk("fetch_mem1", rd, 32'h8C010000);

        d_op(12'h010, 1'b1, 4'hF, 32'hDEADBEEF, rd, lat);
        chk("full_store_lat", lat, 1);
        d_op(12'h010, 1'b0, 4'hF, 32'h0, rd, lat);
        chk("load_after_full", rd, 32'hDEADBEEF);

        preload(10'd4, 32'h12345678);
        d_op(12'h010, 1'b1, 4'b0011, 32'h0000CAFE, rd, lat);
        chk("rmw_pre_word", rd, 32'h12345678);
        chk("rmw_lat", lat, 2);
        d_op(12'h010, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("load_after_rmw", rd, 32'h1234CAFE);
        d_op(12'h010, 1'b1, 4'h0, 32'hFFFFFFFF, rd, lat);
        chk("be0_store_lat", lat, 1);
        chk("be0_mem", mem[4], 32'h1234CAFE);

        // Contention from reset: RR on the main instance, D priority on the other.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        grant_log.delete();
        if_req_valid = 1'b1; if_addr = 12'h008;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 12'h00C; d_be = 4'hF;
        repeat (12) begin
            @(negedge clk);
            chk("fp_if_starved", {31'b0, fp_if_req_ready}, 0);
            if (!fp_busy) chk("fp_d_granted", {31'b0, fp_d_req_ready}, 1);
        end
        chk("rr_grant_count", {31'b0, grant_log.size() >= 4}, 1);
        if (grant_log.size() >= 4) begin
            chk("rr_grant0", grant_log[0], 0);
            chk("rr_grant1", grant_log[1], 1);
            chk("rr_grant2", grant_log[2], 0);
            chk("rr_grant3", grant_log[3], 1);
        end
        @(posedge clk); #1 d_req_valid = 1'b0;
        seen_fp_if = 0;
        repeat (4) begin @(negedge clk); if (fp_if_req_ready) seen_fp_if = 1; end
        chk("fp_if_after_d_drop", {31'b0, seen_fp_if}, 1);
        @(posedge clk); #1 if_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during the RMW write phase must drop the write and the response.
        preload(10'd4, 32'h12345678);
        d_req_valid = 1'b1; d_addr = 12'h010; d_we = 1'b1; d_be = 4'b1100; d_wdata = 32'hAAAA0000;
        lat = 0;
        for (int k = 0; k < 16 && lat == 0; k++) begin @(negedge clk); if (d_req_ready) lat = 1; end
        chk("abort_accept_bound", lat, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("abort_mem_we", {31'b0, mem_we}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_d_rsp", {31'b0, d_rsp_valid}, 0);
        chk("abort_d_ready", {31'b0, d_req_ready}, 0);
        d_req_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        chk("abort_mem4", mem[4], 32'h12345678);
        if_op(12'h004, rd);
        chk("fetch_after_abort", rd, 32'h8C010000);

        // Random traffic on both ports.
        if_seen = if_acc_cnt; d_seen = d_acc_cnt;
        repeat (3000) begin
            @(posedge clk); #1;
            if (if_acc_cnt != if_seen || !if_req_valid) begin
                if_seen = if_acc_cnt;
                if_req_valid = ($urandom_range(0, 2) != 0);
                if_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                if_req_valid = 1'b0;
            end
            if (d_acc_cnt != d_seen || !d_req_valid) begin
                d_seen = d_acc_cnt;
                d_req_valid = ($urandom_range(0, 2) != 0);
                d_addr = rand_addr();
                d_we = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 3))
                    0: be_r = 4'hF;
                    1: be_r = 4'h0;
                    default: be_r = 4'($urandom_range(1, 14));
                endcase
                d_be = be_r;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                d_req_valid = 1'b0;
            end
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) chk("mem_final", mem[i], refm[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
